// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: boots to a reset vector, drives PC source/enable, holds on stalls,
// buffers a branch resolved during a stall, and inserts flush bubbles after every redirect.
module fetch_sequencer #(
    parameter int unsigned     WORD         = 64,
    parameter logic [WORD-1:0] RESET_VECTOR = '0,
    parameter int unsigned     FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_req,
    input  logic            br_valid,
    input  logic [WORD-1:0] br_target,
    output logic            pc_src,
    output logic [WORD-1:0] branch_target,
    output logic            fetch_en,
    output logic            if_id_flush,
    output logic            pend_valid,
    output logic            overrun,
    output logic [15:0]     redirect_count
);

    typedef enum logic [1:0] {BOOT, RUN, STALL, FLUSH} state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam state_t REDIRECT_STATE = (FLUSH_LOAD != 3'd0) ? FLUSH : RUN;

    state_t          state, state_next;
    logic [WORD-1:0] pend_target;
    logic [2:0]      flush_cnt;

    logic            pc_src_d, fetch_en_d, if_id_flush_d, pend_valid_d, overrun_d;
    logic [WORD-1:0] branch_target_d, pend_target_d;
    logic [15:0]     redirect_count_d;
    logic [2:0]      flush_cnt_d;
    logic            issue_redirect;
    logic [WORD-1:0] redirect_target;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= BOOT;
            pc_src         <= 1'b0;
            branch_target  <= '0;
            fetch_en       <= 1'b0;
            if_id_flush    <= 1'b1;
            pend_valid     <= 1'b0;
            pend_target    <= '0;
            overrun        <= 1'b0;
            redirect_count <= 16'd0;
            flush_cnt      <= 3'd0;
        end else begin
            state          <= state_next;
            pc_src         <= pc_src_d;
            branch_target  <= branch_target_d;
            fetch_en       <= fetch_en_d;
            if_id_flush    <= if_id_flush_d;
            pend_valid     <= pend_valid_d;
            pend_target    <= pend_target_d;
            overrun        <= overrun_d;
            redirect_count <= redirect_count_d;
            flush_cnt      <= flush_cnt_d;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:  state_next = RUN;
            RUN: begin
                if (br_valid)       state_next = REDIRECT_STATE;
                else if (stall_req) state_next = STALL;
            end
            STALL: begin
                if (!stall_req) state_next = (pend_valid || br_valid) ? REDIRECT_STATE : RUN;
            end
            FLUSH: begin
                if (br_valid)                state_next = REDIRECT_STATE;
                else if (flush_cnt == 3'd1)  state_next = stall_req ? STALL : RUN;
            end
            default: state_next = BOOT;
        endcase
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        pc_src_d         = 1'b0;
        branch_target_d  = branch_target;
        fetch_en_d       = fetch_en;
        if_id_flush_d    = if_id_flush;
        pend_valid_d     = pend_valid;
        pend_target_d    = pend_target;
        overrun_d        = overrun;
        redirect_count_d = redirect_count;
        flush_cnt_d      = flush_cnt;
        issue_redirect   = 1'b0;
        redirect_target  = br_target;

        case (state)
            BOOT: begin
                pc_src_d        = 1'b1;
                branch_target_d = RESET_VECTOR;
                fetch_en_d      = 1'b1;
                if_id_flush_d   = 1'b1;
            end
            RUN: begin
                if (br_valid) begin
                    issue_redirect = 1'b1;
                end else begin
                    fetch_en_d    = !stall_req;
                    if_id_flush_d = 1'b0;
                end
            end
            STALL: begin
                fetch_en_d    = 1'b0;
                if_id_flush_d = 1'b0;
                if (br_valid && pend_valid) overrun_d = 1'b1;
                if (!stall_req) begin
                    // The buffered branch is older, so it wins over one arriving now.
                    if (pend_valid || br_valid) begin
                        issue_redirect  = 1'b1;
                        redirect_target = pend_valid ? pend_target : br_target;
                        pend_valid_d    = 1'b0;
                    end else begin
                        fetch_en_d = 1'b1;
                    end
                end else if (br_valid && !pend_valid) begin
                    pend_valid_d  = 1'b1;
                    pend_target_d = br_target;
                end
            end
            FLUSH: begin
                if (br_valid) begin
                    issue_redirect = 1'b1;
                end else begin
                    fetch_en_d    = 1'b1;
                    if_id_flush_d = 1'b1;
                    flush_cnt_d   = flush_cnt - 3'd1;
                end
            end
            default: ;
        endcase

        if (issue_redirect) begin
            pc_src_d        = 1'b1;
            branch_target_d = redirect_target;
            fetch_en_d      = 1'b1;
            if_id_flush_d   = 1'b1;
            flush_cnt_d     = FLUSH_LOAD;
            if (redirect_count != 16'hFFFF) redirect_count_d = redirect_count + 16'd1;
        end
    end

endmodule
